// File: rtl/spi_slave.sv
// SPI peripheral endpoint, oversampled on the system clock; all four SPI modes,
// one-deep transmit holding register and a one-cycle receive strobe.
module spi_slave #(
  parameter int         SPI_MODE   = 0,
  parameter logic [7:0] DEFAULT_TX = 8'hFF
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [7:0] i_TX_Byte,
  input  logic       i_TX_DV,
  output logic       o_TX_Ready,
  output logic       o_TX_Underrun,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  input  logic       i_SPI_Clk,
  input  logic       i_SPI_CS_n,
  input  logic       i_SPI_MOSI,
  output logic       o_SPI_MISO,
  output logic       o_SPI_MISO_En
);

  localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
  localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state;

  logic       sck_p0, sck_p1, sck_p2;
  logic       cs_p0, cs_p1, cs_p2;
  logic       mosi_p0, mosi_p1, mosi_p2;

  logic       armed;
  logic [2:0] tx_cnt;
  logic [2:0] rx_cnt;
  logic [6:0] tx_sh;
  logic [6:0] rx_sh;
  logic [7:0] hold;
  logic       tx_ready;
  logic       tx_underrun;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       miso;
  logic       miso_en;

  // Stage p0/p1: two-flop synchronisers; p2: history flop for edge decode
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      {sck_p0, sck_p1, sck_p2}    <= {3{CPOL}};
      {cs_p0, cs_p1, cs_p2}       <= 3'b001;
      {mosi_p0, mosi_p1, mosi_p2} <= 3'b000;
    end else begin
      {sck_p0, sck_p1, sck_p2}    <= {i_SPI_Clk, sck_p0, sck_p1};
      {cs_p0, cs_p1, cs_p2}       <= {i_SPI_CS_n, cs_p0, cs_p1};
      {mosi_p0, mosi_p1, mosi_p2} <= {i_SPI_MOSI, mosi_p0, mosi_p1};
    end
  end

  logic sck_rise, sck_fall, lead_stb, trail_stb, sample_stb, change_stb;
  logic cs_fall, cs_rise;

  assign sck_rise   = sck_p1 & ~sck_p2;
  assign sck_fall   = ~sck_p1 & sck_p2;
  assign lead_stb   = CPOL ? sck_fall : sck_rise;
  assign trail_stb  = CPOL ? sck_rise : sck_fall;
  assign sample_stb = CPHA ? trail_stb : lead_stb;
  assign change_stb = CPHA ? lead_stb : trail_stb;
  assign cs_fall    = ~cs_p1 & cs_p2;
  assign cs_rise    = cs_p1 & ~cs_p2;

  logic       start, stop, load_go, shift_go, sample_go;
  logic [7:0] load_byte;

  // tx_cnt is the index of the next bit to present; 7 means the next change edge loads
  always_comb begin
    start     = (state == IDLE) && armed && cs_fall;
    stop      = (state == ACTIVE) && cs_rise;
    load_go   = 1'b0;
    shift_go  = 1'b0;
    sample_go = 1'b0;
    if ((state == ACTIVE) && !cs_rise) begin
      sample_go = sample_stb;
      if (change_stb) begin
        if (tx_cnt == 3'd7) load_go = 1'b1;
        else                shift_go = 1'b1;
      end
    end
    if (start && !CPHA) load_go = 1'b1;
    load_byte = tx_ready ? DEFAULT_TX : hold;
  end

  // Stage p3: control state and registered outputs
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state       <= IDLE;
      armed       <= 1'b0;
      tx_cnt      <= 3'd7;
      rx_cnt      <= 3'd7;
      tx_ready    <= 1'b1;
      tx_underrun <= 1'b0;
      rx_dv       <= 1'b0;
      rx_byte     <= 8'h00;
      miso        <= 1'b0;
      miso_en     <= 1'b0;
    end else begin
      tx_underrun <= 1'b0;
      rx_dv       <= 1'b0;
      case (state)
        IDLE: begin
          tx_cnt <= 3'd7;
          rx_cnt <= 3'd7;
          // a select fall is honoured only after CS_n has been seen high
          if (cs_p1) armed <= 1'b1;
          if (start) begin
            state   <= ACTIVE;
            miso_en <= 1'b1;
            armed   <= 1'b0;
          end
        end
        ACTIVE: begin
          if (stop) begin
            state   <= IDLE;
            miso_en <= 1'b0;
            miso    <= 1'b0;
            tx_cnt  <= 3'd7;
            rx_cnt  <= 3'd7;
          end
        end
        default: state <= IDLE;
      endcase

      if (load_go) begin
        miso     <= load_byte[7];
        tx_cnt   <= 3'd6;
        tx_ready <= 1'b1;
        if (tx_ready) tx_underrun <= 1'b1;
      end else if (shift_go) begin
        miso   <= tx_sh[6];
        tx_cnt <= tx_cnt - 3'd1;
      end

      if (sample_go) begin
        rx_cnt <= rx_cnt - 3'd1;
        if (rx_cnt == 3'd0) begin
          rx_byte <= {rx_sh, mosi_p2};
          rx_dv   <= 1'b1;
        end
      end

      // a write in the load cycle is kept for the following byte
      if (i_TX_DV && tx_ready) tx_ready <= 1'b0;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_TX_DV && tx_ready) hold <= i_TX_Byte;
    if (load_go)       tx_sh <= load_byte[6:0];
    else if (shift_go) tx_sh <= {tx_sh[5:0], 1'b0};
    if (sample_go)     rx_sh <= {rx_sh[5:0], mosi_p2};
  end

  assign o_TX_Ready    = tx_ready;
  assign o_TX_Underrun = tx_underrun;
  assign o_RX_DV       = rx_dv;
  assign o_RX_Byte     = rx_byte;
  assign o_SPI_MISO    = miso;
  assign o_SPI_MISO_En = miso_en;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one instance per SPI mode, table of single-byte
// exchanges plus hand-written multi-byte, abort, holding-register and reset sequences.
module tb_spi_slave;

  localparam int H = 8;

  logic       i_Clk = 1'b0;
  logic       i_Rst;
  logic [3:0] sck, cs_n, mosi, tx_dv;
  logic [3:0] tx_ready, underrun, rx_dv, miso, miso_en;
  logic [7:0] tx_byte [4];
  logic [7:0] rx_byte [4];

  always #5 i_Clk = ~i_Clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave #(.SPI_MODE(g), .DEFAULT_TX(8'hFF)) dut (
      .i_Clk        (i_Clk),
      .i_Rst        (i_Rst),
      .i_TX_Byte    (tx_byte[g]),
      .i_TX_DV      (tx_dv[g]),
      .o_TX_Ready   (tx_ready[g]),
      .o_TX_Underrun(underrun[g]),
      .o_RX_DV      (rx_dv[g]),
      .o_RX_Byte    (rx_byte[g]),
      .i_SPI_Clk    (sck[g]),
      .i_SPI_CS_n   (cs_n[g]),
      .i_SPI_MOSI   (mosi[g]),
      .o_SPI_MISO   (miso[g]),
      .o_SPI_MISO_En(miso_en[g])
    );
  end

  typedef struct {
    int         mode;
    bit         load;
    logic [7:0] tx;
    logic [7:0] mosi_b;
    logic [7:0] miso_b;
    int         und;
  } vec_t;

  typedef struct {
    int         m;
    logic [7:0] b;
  } rx_t;

  int         n_vec = 0;
  int         n_err = 0;
  int         rxdv_cnt [4] = '{0, 0, 0, 0};
  int         und_cnt  [4] = '{0, 0, 0, 0};
  rx_t        exp_rx[$];
  logic [7:0] exp_miso[$];
  rx_t        mon_e;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic cpol(int m);
    return (m >= 2);
  endfunction

  function automatic logic cpha(int m);
    return (m == 1) || (m == 3);
  endfunction

  // Scoreboard side: every RX_DV pops the oldest expected byte
  always @(negedge i_Clk) begin
    for (int m = 0; m < 4; m++) begin
      if (underrun[m] === 1'b1) und_cnt[m]++;
      if (rx_dv[m] === 1'b1) begin
        rxdv_cnt[m]++;
        if (exp_rx.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rx_unexpected: mode %0d got %0h required no pulse", m, rx_byte[m]);
        end else begin
          mon_e = exp_rx.pop_front();
          check("rx_mode", m, mon_e.m);
          check("rx_byte_at_dv", rx_byte[m], mon_e.b);
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge i_Clk);
    #1;
  endtask

  task automatic write_tx(int m, logic [7:0] b);
    tx_byte[m] = b;
    tx_dv[m]   = 1'b1;
    tick(1);
    tx_dv[m]   = 1'b0;
  endtask

  task automatic cs_low(int m);
    cs_n[m] = 1'b0;
    tick(H);
  endtask

  task automatic cs_high(int m);
    tick(H);
    cs_n[m] = 1'b1;
    tick(H);
  endtask

  task automatic xfer_bits(int m, logic [7:0] out, int nbits, output logic [7:0] in);
    in = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpha(m)) begin
        mosi[m] = out[i];
        tick(H);
        in[i]  = miso[m];
        sck[m] = ~sck[m];
        tick(H);
        sck[m] = ~sck[m];
      end else begin
        sck[m]  = ~sck[m];
        mosi[m] = out[i];
        tick(H);
        in[i]  = miso[m];
        sck[m] = ~sck[m];
        tick(H);
      end
    end
  endtask

  task automatic run_byte(int m, logic [7:0] out, logic [7:0] want_miso);
    logic [7:0] got;
    logic [7:0] e;
    rx_t        r;
    r.m = m;
    r.b = out;
    exp_rx.push_back(r);
    exp_miso.push_back(want_miso);
    xfer_bits(m, out, 8, got);
    e = exp_miso.pop_front();
    check("miso_byte", got, e);
  endtask

  vec_t       vec [7];
  int         m, r0, u0;
  logic [7:0] junk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec[0] = '{0, 1'b1, 8'hA5, 8'h3C, 8'hA5, 1};
    vec[1] = '{1, 1'b0, 8'h00, 8'h55, 8'hFF, 1};
    vec[2] = '{2, 1'b1, 8'h96, 8'h0F, 8'h96, 1};
    vec[3] = '{3, 1'b1, 8'h00, 8'hFF, 8'h00, 0};
    vec[4] = '{0, 1'b0, 8'h00, 8'h80, 8'hFF, 2};
    vec[5] = '{3, 1'b1, 8'h01, 8'h01, 8'h01, 0};
    vec[6] = '{1, 1'b1, 8'hC7, 8'hE1, 8'hC7, 0};

    for (int k = 0; k < 4; k++) begin
      sck[k]     = cpol(k);
      tx_byte[k] = 8'h00;
    end
    cs_n  = 4'hF;
    mosi  = 4'h0;
    tx_dv = 4'h0;
    i_Rst = 1'b1;
    tick(3);
    i_Rst = 1'b0;
    tick(H);

    for (int k = 0; k < 4; k++) begin
      check("reset_tx_ready", tx_ready[k], 1);
      check("reset_miso_en", miso_en[k], 0);
      check("reset_miso", miso[k], 0);
      check("reset_rx_byte", rx_byte[k], 8'h00);
    end
    check("reset_pulses", {underrun, rx_dv}, 8'h00);

    for (int v = 0; v < 7; v++) begin
      m  = vec[v].mode;
      r0 = rxdv_cnt[m];
      u0 = und_cnt[m];
      if (vec[v].load) begin
        write_tx(m, vec[v].tx);
        check("tx_ready_after_write", tx_ready[m], 0);
      end
      cs_low(m);
      check("miso_en_selected", miso_en[m], 1);
      run_byte(m, vec[v].mosi_b, vec[v].miso_b);
      cs_high(m);
      check("miso_en_deselected", miso_en[m], 0);
      check("tx_ready_after_load", tx_ready[m], 1);
      check("rx_byte_held", rx_byte[m], vec[v].mosi_b);
      check("rx_dv_count", rxdv_cnt[m] - r0, 1);
      check("underrun_count", und_cnt[m] - u0, vec[v].und);
    end

    // Mode 3: three bytes under one select, refilled on TX_Ready
    r0 = rxdv_cnt[3];
    u0 = und_cnt[3];
    write_tx(3, 8'h11);
    cs_low(3);
    run_byte(3, 8'hDE, 8'h11);
    check("m3_ready_1", tx_ready[3], 1);
    write_tx(3, 8'h22);
    run_byte(3, 8'hAD, 8'h22);
    check("m3_ready_2", tx_ready[3], 1);
    write_tx(3, 8'h33);
    run_byte(3, 8'hBE, 8'h33);
    cs_high(3);
    check("m3_rx_dv_count", rxdv_cnt[3] - r0, 3);
    check("m3_underrun_count", und_cnt[3] - u0, 0);

    // Mode 1: second write while full is dropped
    u0 = und_cnt[1];
    write_tx(1, 8'h12);
    write_tx(1, 8'h77);
    check("full_write_ready", tx_ready[1], 0);
    cs_low(1);
    run_byte(1, 8'h5A, 8'h12);
    run_byte(1, 8'h3C, 8'hFF);
    cs_high(1);
    check("full_write_underrun", und_cnt[1] - u0, 1);

    // Mode 0: write coinciding with the select-fall load goes to the next byte
    u0 = und_cnt[0];
    cs_n[0] = 1'b0;
    tick(2);
    tx_byte[0] = 8'h5A;
    tx_dv[0]   = 1'b1;
    tick(1);
    tx_dv[0]   = 1'b0;
    check("coincide_ready", tx_ready[0], 0);
    tick(H - 3);
    run_byte(0, 8'h24, 8'hFF);
    run_byte(0, 8'h99, 8'h5A);
    cs_high(0);
    check("coincide_underrun", und_cnt[0] - u0, 2);

    // Mode 2: abort after five bits
    r0 = rxdv_cnt[2];
    cs_low(2);
    xfer_bits(2, 8'hF8, 5, junk);
    check("abort_miso_en_before", miso_en[2], 1);
    cs_high(2);
    check("abort_miso_en_after", miso_en[2], 0);
    check("abort_no_rx_dv", rxdv_cnt[2] - r0, 0);
    cs_low(2);
    run_byte(2, 8'h81, 8'hFF);
    cs_high(2);
    check("abort_next_rx", rx_byte[2], 8'h81);
    check("abort_rx_dv_count", rxdv_cnt[2] - r0, 1);

    // Mode 0: reset mid-byte
    r0 = rxdv_cnt[0];
    write_tx(0, 8'h66);
    cs_low(0);
    xfer_bits(0, 8'hC3, 4, junk);
    write_tx(0, 8'h42);
    check("rst_pre_ready", tx_ready[0], 0);
    check("rst_pre_miso_en", miso_en[0], 1);
    i_Rst = 1'b1;
    tick(1);
    check("rst_tx_ready", tx_ready[0], 1);
    check("rst_underrun", underrun[0], 0);
    check("rst_rx_dv", rx_dv[0], 0);
    check("rst_rx_byte", rx_byte[0], 8'h00);
    check("rst_miso", miso[0], 0);
    check("rst_miso_en", miso_en[0], 0);
    i_Rst = 1'b0;
    tick(H);
    check("rst_stays_idle", miso_en[0], 0);
    cs_n[0] = 1'b1;
    tick(H);
    cs_low(0);
    run_byte(0, 8'hC3, 8'hFF);
    cs_high(0);
    check("rst_next_rx", rx_byte[0], 8'hC3);
    check("rst_rx_dv_count", rxdv_cnt[0] - r0, 1);

    tick(20);
    check("rx_queue_drained", exp_rx.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
